// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants.
// Used by branch_resolve_unit, branch_cmp and the fetch-side branch_predictor.
//   bp_state_t    : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   BR_*          : funct3 codes of the conditional branches
//   res_state_t   : resolver FSM states
//   bp_update_t   : update packet sent back to the predictor
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_t;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic {
        RES_IDLE   = 1'b0,
        RES_SQUASH = 1'b1
    } res_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        bp_state_t   state;
    } bp_update_t;

    // Saturating 2-bit counter step: taken moves towards ST, not-taken
    // towards SNT, and the end states stick.
    function automatic bp_state_t bp_next_state(bp_state_t cur, logic taken);
        bp_state_t nxt;
        if (taken) begin
            nxt = (cur == ST) ? ST : bp_state_t'(cur + 2'd1);
        end else begin
            nxt = (cur == SNT) ? SNT : bp_state_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Ports:
//   funct3_i  : branch condition code
//   rs1_i     : first operand
//   rs2_i     : second operand
//   taken_o   : condition holds (forced low for illegal codes)
//   illegal_o : funct3 is not a conditional-branch encoding (010/011)
module branch_cmp (
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o,
    output logic        illegal_o
);
    import bp_pkg::*;

    // Decode the condition; codes 010 and 011 have no branch meaning, so
    // they report not-taken and raise illegal so the resolver ignores them.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BR_BEQ:  taken_o = (rs1_i == rs2_i);
            BR_BNE:  taken_o = (rs1_i != rs2_i);
            BR_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: taken_o = (rs1_i <  rs2_i);
            BR_BGEU: taken_o = (rs1_i >= rs2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver. Evaluates conditional branches, checks them
// against the fetch-time prediction, returns a registered predictor update,
// redirects the PC and flushes IF/ID and ID/EX on a mispredict, and keeps
// saturating branch / mispredict counters.
// Ports:
//   clk, rst (async, active low)
//   ex_*             : branch instruction currently in ID/EX
//   perf_clr         : synchronous clear of both counters
//   update_en, branch_taken, resolved_pc, resolved_target, resolved_state
//                    : predictor update packet (one-cycle strobe)
//   redirect_valid, redirect_pc, flush_if_id, flush_id_ex : mispredict recovery
//   branch_count, mispredict_count : performance counters
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1_val,
    input  logic [31:0]      ex_rs2_val,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic [1:0]       ex_bp_state,
    input  logic             perf_clr,
    output logic             update_en,
    output logic             branch_taken,
    output logic [31:0]      resolved_pc,
    output logic [31:0]      resolved_target,
    output logic [1:0]       resolved_state,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    import bp_pkg::*;

    res_state_t       state_q, state_d;
    bp_update_t       upd_q, upd_d;
    logic             update_en_q, update_en_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             cmp_taken;
    logic             cmp_illegal;
    logic [31:0]      target;
    logic [31:0]      fall_through;
    logic             eval;
    logic             legal;
    logic             mispredict;

    branch_cmp u_cmp (
        .funct3_i  (ex_funct3),
        .rs1_i     (ex_rs1_val),
        .rs2_i     (ex_rs2_val),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    // Both addresses wrap naturally in 32 bits. The instruction in EX during
    // SQUASH is wrong-path, so evaluation is gated on the FSM being IDLE;
    // a stalled branch waits and is evaluated on the first unstalled cycle.
    assign target       = ex_pc + ex_imm;
    assign fall_through = ex_pc + 32'd4;
    assign eval         = ex_valid & ex_branch & ~ex_stall & (state_q == RES_IDLE);
    assign legal        = eval & ~cmp_illegal;
    assign mispredict   = legal & ((cmp_taken != ex_pred_taken) |
                                   (cmp_taken & (ex_pred_target != target)));

    // Next-state logic: resolver FSM, update packet, redirect and counters.
    // The update packet and redirect PC hold their last value between
    // strobes; perf_clr takes priority over any increment.
    always_comb begin
        state_d       = state_q;
        upd_d         = upd_q;
        update_en_d   = legal;
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            RES_IDLE:   if (mispredict) state_d = RES_SQUASH;
            RES_SQUASH: state_d = RES_IDLE;
            default:    state_d = RES_IDLE;
        endcase

        if (legal) begin
            upd_d.pc     = ex_pc;
            upd_d.target = target;
            upd_d.taken  = cmp_taken;
            upd_d.state  = bp_next_state(bp_state_t'(ex_bp_state), cmp_taken);
        end

        if (mispredict) begin
            redirect_pc_d = cmp_taken ? target : fall_through;
        end

        if (perf_clr) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (legal && (branch_cnt_q != {CNT_W{1'b1}})) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    // State register; reset drops any pending squash and clears all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RES_IDLE;
            upd_q         <= '0;
            update_en_q   <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            upd_q         <= upd_d;
            update_en_q   <= update_en_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Redirect and both flushes come from one register so they can never
    // disagree; ID/EX flush is not gated by the stall.
    assign update_en        = update_en_q;
    assign branch_taken     = upd_q.taken;
    assign resolved_pc      = upd_q.pc;
    assign resolved_target  = upd_q.target;
    assign resolved_state   = upd_q.state;
    assign redirect_valid   = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush_if_id      = redirect_q;
    assign flush_id_ex      = redirect_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run, all checked against a behavioural model of the resolver.
module tb_branch_resolve_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ex_valid, ex_stall, ex_branch;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic [1:0]       ex_bp_state;
    logic             perf_clr;
    logic             update_en, branch_taken;
    logic [31:0]      resolved_pc, resolved_target;
    logic [1:0]       resolved_state;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    int nCompared   = 0;
    int nMismatched = 0;

    // Behavioural model: expected outputs after the next clock edge.
    bit          mSquash;
    bit          mUpd, mTaken, mRv;
    logic [31:0] mPc, mTgt, mRpc;
    logic [1:0]  mState;
    int          mBc, mMc;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_branch        (ex_branch),
        .ex_funct3        (ex_funct3),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_rs1_val       (ex_rs1_val),
        .ex_rs2_val       (ex_rs2_val),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_bp_state      (ex_bp_state),
        .perf_clr         (perf_clr),
        .update_en        (update_en),
        .branch_taken     (branch_taken),
        .resolved_pc      (resolved_pc),
        .resolved_target  (resolved_target),
        .resolved_state   (resolved_state),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mSquash = 0; mUpd = 0; mTaken = 0; mRv = 0;
        mPc = 0; mTgt = 0; mRpc = 0; mState = 0;
        mBc = 0; mMc = 0;
    endtask

    // Apply the resolver rules to the inputs currently driven.
    task automatic model_step();
        bit          canEval, legalOp, tk, misp;
        logic [31:0] tgt;
        int          s;
        canEval = ex_valid && ex_branch && !ex_stall && !mSquash;
        legalOp = !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        case (ex_funct3)
            3'd0: tk = (ex_rs1_val == ex_rs2_val);
            3'd1: tk = (ex_rs1_val != ex_rs2_val);
            3'd4: tk = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'd5: tk = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'd6: tk = (ex_rs1_val <  ex_rs2_val);
            3'd7: tk = (ex_rs1_val >= ex_rs2_val);
            default: tk = 0;
        endcase
        tgt  = ex_pc + ex_imm;
        mUpd = canEval && legalOp;
        misp = mUpd && ((tk != ex_pred_taken) || (tk && ex_pred_target != tgt));
        if (mUpd) begin
            mTaken = tk;
            mPc    = ex_pc;
            mTgt   = tgt;
            s      = int'(ex_bp_state);
            s      = tk ? ((s < 3) ? s + 1 : 3) : ((s > 0) ? s - 1 : 0);
            mState = 2'(s);
        end
        mRv = misp;
        if (misp) mRpc = tk ? tgt : ex_pc + 32'd4;
        if (perf_clr) begin
            mBc = 0;
            mMc = 0;
        end else begin
            if (mUpd && mBc < CNT_MAX) mBc++;
            if (misp && mMc < CNT_MAX) mMc++;
        end
        mSquash = misp;
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_funct3 = 0;
        ex_pc = 0; ex_imm = 0; ex_rs1_val = 0; ex_rs2_val = 0;
        ex_pred_taken = 0; ex_pred_target = 0; ex_bp_state = 0; perf_clr = 0;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b, input logic pt,
                                input logic [31:0] ptgt, input logic [1:0] st);
        ex_valid = 1; ex_branch = 1; ex_stall = 0; ex_funct3 = f3;
        ex_pc = pc; ex_imm = imm; ex_rs1_val = a; ex_rs2_val = b;
        ex_pred_taken = pt; ex_pred_target = ptgt; ex_bp_state = st;
    endtask

    // Advance one cycle and land 1 time unit past the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        model_reset();
        #12;
        nCompared++;
        if ({update_en, redirect_valid, flush_if_id, flush_id_ex, branch_taken} !== 5'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_pulses got %b want 00000",
                     {update_en, redirect_valid, flush_if_id, flush_id_ex, branch_taken});
        end
        nCompared++;
        if ({resolved_pc, resolved_target, redirect_pc} !== 96'h0 || resolved_state !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_resolved got pc=%h tgt=%h rpc=%h st=%b want 0",
                     resolved_pc, resolved_target, redirect_pc, resolved_state);
        end
        nCompared++;
        if (branch_count !== '0 || mispredict_count !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", branch_count, mispredict_count);
        end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_beq_mispredict();
        drive_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 2'b01);
        tick();
        nCompared++;
        if (update_en !== 1'b1 || branch_taken !== 1'b1 || resolved_target !== 32'h120 ||
            resolved_pc !== 32'h100 || resolved_state !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL beq_update got en=%b tk=%b pc=%h tgt=%h st=%b want 1 1 100 120 10",
                     update_en, branch_taken, resolved_pc, resolved_target, resolved_state);
        end
        nCompared++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL beq_redirect got rv=%b rpc=%h fl=%b%b want 1 120 11",
                     redirect_valid, redirect_pc, flush_if_id, flush_id_ex);
        end
        nCompared++;
        if (mispredict_count !== 4'd1 || branch_count !== 4'd1) begin
            nMismatched++;
            $display("[TB] FAIL beq_counters got bc=%0d mc=%0d want 1/1", branch_count, mispredict_count);
        end
        drive_idle();
        tick();
        nCompared++;
        if (update_en !== 1'b0 || redirect_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL beq_one_cycle got en=%b rv=%b want 0 0", update_en, redirect_valid);
        end
    endtask

    task automatic test_bne_correct();
        int bc0, mc0;
        bc0 = mBc; mc0 = mMc;
        drive_branch(3'b001, 32'h180, 32'h10, 32'd3, 32'd3, 1'b0, 32'h0, 2'b00);
        tick();
        nCompared++;
        if (update_en !== 1'b1 || branch_taken !== 1'b0 || resolved_state !== 2'b00 ||
            redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bne_correct got en=%b tk=%b st=%b rv=%b fl=%b%b want 1 0 00 0 00",
                     update_en, branch_taken, resolved_state, redirect_valid, flush_if_id, flush_id_ex);
        end
        nCompared++;
        if (int'(branch_count) != bc0 + 1 || int'(mispredict_count) != mc0) begin
            nMismatched++;
            $display("[TB] FAIL bne_counters got bc=%0d mc=%0d want %0d/%0d",
                     branch_count, mispredict_count, bc0 + 1, mc0);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_blt_bltu();
        drive_branch(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 2'b01);
        tick();
        nCompared++;
        if (branch_taken !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin
            nMismatched++;
            $display("[TB] FAIL blt_signed got tk=%b rv=%b rpc=%h want 1 1 240",
                     branch_taken, redirect_valid, redirect_pc);
        end
        drive_idle();
        tick();
        drive_branch(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240, 2'b01);
        tick();
        nCompared++;
        if (branch_taken !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || resolved_state !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL bltu_unsigned got tk=%b rv=%b rpc=%h st=%b want 0 1 204 00",
                     branch_taken, redirect_valid, redirect_pc, resolved_state);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_squash_window();
        int bc0, mc0;
        drive_branch(3'b101, 32'h300, 32'hFFFF_FFF8, 32'd7, 32'd2, 1'b0, 32'h0, 2'b01);
        tick();
        nCompared++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2F8) begin
            nMismatched++;
            $display("[TB] FAIL squash_trigger got rv=%b rpc=%h want 1 2f8", redirect_valid, redirect_pc);
        end
        bc0 = mBc; mc0 = mMc;
        drive_branch(3'b000, 32'h400, 32'h20, 32'd1, 32'd1, 1'b0, 32'h0, 2'b00);
        tick();
        nCompared++;
        if (update_en !== 1'b0 || redirect_valid !== 1'b0 || int'(branch_count) != bc0 || int'(mispredict_count) != mc0) begin
            nMismatched++;
            $display("[TB] FAIL squash_ignored got en=%b rv=%b bc=%0d mc=%0d want 0 0 %0d %0d",
                     update_en, redirect_valid, branch_count, mispredict_count, bc0, mc0);
        end
        drive_branch(3'b001, 32'h500, 32'h10, 32'd1, 32'd2, 1'b1, 32'h510, 2'b10);
        tick();
        nCompared++;
        if (update_en !== 1'b1 || redirect_valid !== 1'b0 || resolved_pc !== 32'h500 || resolved_state !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL squash_idle_restored got en=%b rv=%b pc=%h st=%b want 1 0 500 11",
                     update_en, redirect_valid, resolved_pc, resolved_state);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_stall();
        drive_branch(3'b111, 32'h600, 32'h80, 32'd9, 32'd3, 1'b1, 32'h680, 2'b10);
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++;
            if (update_en !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold[%0d] got en=%b want 0", i, update_en);
            end
        end
        ex_stall = 0;
        tick();
        nCompared++;
        if (update_en !== 1'b1 || resolved_pc !== 32'h600 || resolved_state !== 2'b11 || redirect_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL stall_release got en=%b pc=%h st=%b rv=%b want 1 600 11 0",
                     update_en, resolved_pc, resolved_state, redirect_valid);
        end
        drive_idle();
        tick();
        nCompared++;
        if (update_en !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL stall_single got en=%b want 0", update_en);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            drive_branch(3'b000, 32'h700, 32'h8, 32'd4, 32'd4, 1'b1, 32'h708, 2'b11);
            tick();
        end
        nCompared++;
        if (branch_count !== 4'hF) begin
            nMismatched++;
            $display("[TB] FAIL sat_branch got %0d want 15", branch_count);
        end
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            drive_branch(3'b000, 32'h700, 32'h8, 32'd4, 32'd4, 1'b0, 32'h0, 2'b00);
            tick();
            drive_idle();
            tick();
        end
        nCompared++;
        if (mispredict_count !== 4'hF || branch_count !== 4'hF) begin
            nMismatched++;
            $display("[TB] FAIL sat_mispredict got bc=%0d mc=%0d want 15/15", branch_count, mispredict_count);
        end
        drive_branch(3'b000, 32'h700, 32'h8, 32'd4, 32'd4, 1'b0, 32'h0, 2'b00);
        perf_clr = 1;
        tick();
        nCompared++;
        if (mispredict_count !== 4'h0 || branch_count !== 4'h0 || redirect_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL perf_clr_wins got bc=%0d mc=%0d rv=%b want 0 0 1",
                     branch_count, mispredict_count, redirect_valid);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_in_squash();
        drive_branch(3'b001, 32'h800, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0, 2'b01);
        tick();
        drive_branch(3'b000, 32'h900, 32'h20, 32'd1, 32'd1, 1'b0, 32'h0, 2'b00);
        #2;
        rst = 0;
        model_reset();
        #1;
        nCompared++;
        if ({update_en, redirect_valid, flush_if_id, flush_id_ex, branch_taken} !== 5'b0 ||
            {resolved_pc, resolved_target, redirect_pc} !== 96'h0 || resolved_state !== 2'b00 ||
            branch_count !== '0 || mispredict_count !== '0) begin
            nMismatched++;
            $display("[TB] FAIL squash_reset got en=%b rv=%b fl=%b%b pc=%h tgt=%h rpc=%h bc=%0d mc=%0d want all 0",
                     update_en, redirect_valid, flush_if_id, flush_id_ex, resolved_pc, resolved_target,
                     redirect_pc, branch_count, mispredict_count);
        end
        @(negedge clk);
        rst = 1;
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            nCompared++;
            if (update_en !== 1'b0 || redirect_valid !== 1'b0 || flush_id_ex !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL squash_reset_after[%0d] got en=%b rv=%b fl=%b want 0 0 0",
                         i, update_en, redirect_valid, flush_id_ex);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'd5;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ex_valid       = ($urandom_range(0, 9) < 8);
            ex_branch      = ($urandom_range(0, 9) < 8);
            ex_stall       = ($urandom_range(0, 3) == 0);
            ex_funct3      = 3'($urandom_range(0, 7));
            ex_pc          = (i % 16 == 0) ? 32'hFFFF_FFFC : $urandom;
            ex_imm         = $urandom;
            ex_rs1_val     = pick_operand();
            ex_rs2_val     = pick_operand();
            ex_pred_taken  = 1'($urandom_range(0, 1));
            ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_pc + ex_imm : $urandom;
            ex_bp_state    = 2'($urandom_range(0, 3));
            perf_clr       = ($urandom_range(0, 29) == 0);
            tick();
            nCompared++;
            if (update_en !== mUpd || redirect_valid !== mRv || flush_if_id !== mRv || flush_id_ex !== mRv) begin
                nMismatched++;
                $display("[TB] FAIL rand_pulses[%0d] got en=%b rv=%b fl=%b%b want en=%b rv=%b",
                         i, update_en, redirect_valid, flush_if_id, flush_id_ex, mUpd, mRv);
            end
            nCompared++;
            if (branch_taken !== mTaken || resolved_pc !== mPc || resolved_target !== mTgt || resolved_state !== mState) begin
                nMismatched++;
                $display("[TB] FAIL rand_packet[%0d] got tk=%b pc=%h tgt=%h st=%b want tk=%b pc=%h tgt=%h st=%b",
                         i, branch_taken, resolved_pc, resolved_target, resolved_state, mTaken, mPc, mTgt, mState);
            end
            nCompared++;
            if (redirect_pc !== mRpc || int'(branch_count) != mBc || int'(mispredict_count) != mMc) begin
                nMismatched++;
                $display("[TB] FAIL rand_redirect_cnt[%0d] got rpc=%h bc=%0d mc=%0d want rpc=%h bc=%0d mc=%0d",
                         i, redirect_pc, branch_count, mispredict_count, mRpc, mBc, mMc);
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_beq_mispredict();
        test_bne_correct();
        test_blt_bltu();
        test_squash_window();
        test_stall();
        test_saturation();
        test_reset_in_squash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
